// File: rtl/xintc_pkg.sv
// xintc package: interrupt-controller sizing, state encodings and helpers.
// Optional build macro: XINTC_LEVEL_EN (level-triggered pending register).
package xintc_pkg;

    // Number of interrupt lines; the encoder input is fixed at 32 bits.
    localparam int N_IRQ = 32;
    // Width of an interrupt ID, log2(N_IRQ).
    localparam int ID_W  = 5;

    // Arbitration state encodings, kept as plain constants for legacy tools.
    localparam logic [1:0] XINTC_IDLE = 2'd0;
    localparam logic [1:0] XINTC_PEND = 2'd1;
    localparam logic [1:0] XINTC_SERV = 2'd2;

    typedef logic [N_IRQ-1:0] irq_vec_t;
    typedef logic [ID_W-1:0]  irq_id_t;

    // One-hot vector selecting the pending bit of a given interrupt ID.
    function automatic irq_vec_t idOneHot(input irq_id_t id);
        irq_vec_t v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/xintc_if.sv
// xintc bus interface: interrupt lines, mask access and the core handshake.
// The master side (core/CSR unit) drives requests; the slave side is xintc.
interface xintc_if;
    import xintc_pkg::*;

    irq_vec_t irq_in;
    logic     gie;
    logic     mask_we;
    irq_vec_t mask_wdata;
    irq_vec_t mask_out;
    irq_vec_t pend_out;
    logic     int_req;
    irq_id_t  int_id;
    logic     int_ack;
    logic     int_done;

    modport master (
        output irq_in, gie, mask_we, mask_wdata, int_ack, int_done,
        input  mask_out, pend_out, int_req, int_id
    );

    modport slave (
        input  irq_in, gie, mask_we, mask_wdata, int_ack, int_done,
        output mask_out, pend_out, int_req, int_id
    );

endinterface

// File: rtl/xintc_xencdr.sv
// xencdr: combinational lowest-index priority encoder over 32 inputs.
// Index 0 wins; the output is 0 when no input is set.
module xencdr
    import xintc_pkg::*;
(
    input  irq_vec_t val_in,
    output irq_id_t  idx_out
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx_out = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (val_in[i]) begin
                idx_out = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/xintc.sv
// xintc: interrupt pending/mask stage with req/ack/done handshake to the core.
// Build macro XINTC_LEVEL_EN: when defined, pending mirrors irq_in each cycle
// (level-triggered, no ack clear); otherwise rising edges set pending bits.
module xintc
    import xintc_pkg::*;
(
    input logic   clk,
    input logic   rst,
    xintc_if.slave bus
);

    irq_vec_t   r_pend;
    irq_vec_t   r_mask;
    logic [1:0] r_state;
    logic       r_req;
    irq_id_t    r_id;

    irq_vec_t   w_eff;
    irq_id_t    w_enc_id;
    logic       w_any;
    logic       w_ack_pend;
    logic [1:0] w_next_state;

    assign w_eff      = r_pend & r_mask;
    assign w_any      = |w_eff;
    assign w_ack_pend = (r_state == XINTC_PEND) && bus.int_ack;

    xencdr u_encdr (
        .val_in  (w_eff),
        .idx_out (w_enc_id)
    );

`ifdef XINTC_LEVEL_EN
    // Pending simply follows the lines; the source clears it in its handler.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= bus.irq_in;
        end
    end
`else
    irq_vec_t r_irq_q;
    irq_vec_t w_rise;
    irq_vec_t w_clr;

    assign w_rise = bus.irq_in & ~r_irq_q;
    assign w_clr  = w_ack_pend ? idOneHot(r_id) : '0;

    // Capture rising edges; a fresh edge outranks the ack clear on the same bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_q <= '0;
            r_pend  <= '0;
        end else begin
            r_irq_q <= bus.irq_in;
            r_pend  <= (r_pend & ~w_clr) | w_rise;
        end
    end
`endif

    // Software mask register; a write is visible to arbitration next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '0;
        end else if (bus.mask_we) begin
            r_mask <= bus.mask_wdata;
        end
    end

    // Next-state logic: one request outstanding at a time, no nesting.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            XINTC_IDLE: if (bus.gie && w_any) w_next_state = XINTC_PEND;
            XINTC_PEND: if (bus.int_ack)      w_next_state = XINTC_SERV;
            XINTC_SERV: if (bus.int_done)     w_next_state = XINTC_IDLE;
            default:                          w_next_state = XINTC_IDLE;
        endcase
    end

    // State, registered request and the ID frozen when leaving IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= XINTC_IDLE;
            r_req   <= 1'b0;
            r_id    <= '0;
        end else begin
            r_state <= w_next_state;
            r_req   <= (w_next_state == XINTC_PEND);
            if (r_state == XINTC_IDLE && bus.gie && w_any) begin
                r_id <= w_enc_id;
            end
        end
    end

    assign bus.mask_out = r_mask;
    assign bus.pend_out = r_pend;
    assign bus.int_req  = r_req;
    assign bus.int_id   = r_id;

endmodule

// File: tb/tb_xintc.sv
// tb_xintc: directed scenarios plus randomized traffic for xintc, checked
// every cycle against a behavioural model of the pending/arbitration rules.
// Honors XINTC_LEVEL_EN the same way the design does.
module tb_xintc;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    xintc_if bus ();

    xintc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 = waiting, 1 = requesting, 2 = in handler.
    logic [31:0] mPend;
    logic [31:0] mMask;
    logic [31:0] mPrev;
    int          mPhase;
    int          mId;

    initial begin
        mPend  = '0;
        mMask  = '0;
        mPrev  = '0;
        mPhase = 0;
        mId    = 0;
    end

    // Advance the model by one clock using the inputs present at the edge.
    always @(posedge clk) begin
        logic [31:0] nxtPend;
        int          lowest;
        if (rst) begin
            mPend  = '0;
            mMask  = '0;
            mPrev  = '0;
            mPhase = 0;
            mId    = 0;
        end else begin
            lowest = -1;
            for (int i = 0; i < 32; i++) begin
                if (lowest < 0 && mPend[i] && mMask[i]) lowest = i;
            end
`ifdef XINTC_LEVEL_EN
            nxtPend = bus.irq_in;
`else
            nxtPend = mPend;
            if (mPhase == 1 && bus.int_ack) nxtPend[mId] = 1'b0;
            for (int i = 0; i < 32; i++) begin
                if (bus.irq_in[i] && !mPrev[i]) nxtPend[i] = 1'b1;
            end
`endif
            if (mPhase == 0) begin
                if (bus.gie && lowest >= 0) begin
                    mId    = lowest;
                    mPhase = 1;
                end
            end else if (mPhase == 1) begin
                if (bus.int_ack) mPhase = 2;
            end else begin
                if (bus.int_done) mPhase = 0;
            end
            mPend = nxtPend;
            mPrev = bus.irq_in;
            if (bus.mask_we) mMask = bus.mask_wdata;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rstV, input logic [31:0] irqV,
                                 input logic gieV, input logic weV,
                                 input logic [31:0] wdataV, input logic ackV,
                                 input logic doneV);
        rst            = rstV;
        bus.irq_in     = irqV;
        bus.gie        = gieV;
        bus.mask_we    = weV;
        bus.mask_wdata = wdataV;
        bus.int_ack    = ackV;
        bus.int_done   = doneV;
    endtask

    // One clock, then compare every output against the model mid-cycle.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        checkOutput("pend_out", bus.pend_out, mPend);
        checkOutput("mask_out", bus.mask_out, mMask);
        checkOutput("int_req", {31'b0, bus.int_req}, {31'b0, (mPhase == 1)});
        checkOutput("int_id", {27'b0, bus.int_id}, 32'(mId));
    endtask

    function automatic logic [31:0] bitv(input int i);
        logic [31:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [31:0] irqR;
        checks = 0;
        errors = 0;
        applyStimulus(1'b1, 32'h1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("reset_pend", bus.pend_out, 32'h0);
        checkOutput("reset_req", {31'b0, bus.int_req}, 32'h0);
        checkOutput("reset_id", {27'b0, bus.int_id}, 32'h0);
        applyStimulus(1'b0, 32'h1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        checkOutput("post_reset_pend", bus.pend_out, 32'h1);
        checkOutput("post_reset_req", {31'b0, bus.int_req}, 32'h0);

`ifndef XINTC_LEVEL_EN
        // Drain bit 0 after enabling everything.
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        tick();
        checkOutput("drain_id0", {27'b0, bus.int_id}, 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        tick();

        // Basic flow on line 5: two cycles from edge to request.
        applyStimulus(1'b0, bitv(5), 1'b1, 1'b0, '0, 1'b0, 1'b0);
        tick();
        checkOutput("basic_pend5", bus.pend_out, bitv(5));
        checkOutput("basic_req_early", {31'b0, bus.int_req}, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        tick();
        checkOutput("basic_req", {31'b0, bus.int_req}, 32'h1);
        checkOutput("basic_id5", {27'b0, bus.int_id}, 32'd5);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("ack_clear5", bus.pend_out, 32'h0);
        checkOutput("ack_req_low", {31'b0, bus.int_req}, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        tick();

        // Priority and freeze: 9 and 3 together, then 1 arrives while pending.
        applyStimulus(1'b0, bitv(9) | bitv(3), 1'b1, 1'b0, '0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        tick();
        checkOutput("prio_id3", {27'b0, bus.int_id}, 32'd3);
        applyStimulus(1'b0, bitv(1), 1'b1, 1'b0, '0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("freeze_id3", {27'b0, bus.int_id}, 32'd3);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
            tick();
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
            tick();
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
            tick();
            checkOutput("next_req", {31'b0, bus.int_req}, 32'h1);
            checkOutput("next_id", {27'b0, bus.int_id}, (k == 0) ? 32'd1 : 32'd9);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        tick();

        // Masking and gie: mask 0x10 with lines 2 and 4, gie low first.
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h14, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("gie_off_req", {31'b0, bus.int_req}, 32'h0);
        checkOutput("gie_off_pend", bus.pend_out, 32'h14);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        tick();
        checkOutput("mask_id4", {27'b0, bus.int_id}, 32'd4);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        tick();

        // Set/clear collision on line 7 from a clean reset.
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, bitv(7), 1'b1, 1'b0, '0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        tick();
        checkOutput("coll_id7", {27'b0, bus.int_id}, 32'd7);
        applyStimulus(1'b0, bitv(7), 1'b1, 1'b0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("coll_pend7", bus.pend_out & bitv(7), bitv(7));
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        tick();
        checkOutput("coll_serv_req", {31'b0, bus.int_req}, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        tick();
        checkOutput("coll_rereq7", {27'b0, bus.int_id}, 32'd7);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        tick();
`else
        // Level mode: line 2 held high is re-requested after the handler.
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, bitv(2), 1'b1, 1'b0, '0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("lvl_id2", {27'b0, bus.int_id}, 32'd2);
        applyStimulus(1'b0, bitv(2), 1'b1, 1'b0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("lvl_pend_held", bus.pend_out, bitv(2));
        applyStimulus(1'b0, bitv(2), 1'b1, 1'b0, '0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, bitv(2), 1'b1, 1'b0, '0, 1'b0, 1'b0);
        tick();
        checkOutput("lvl_rereq", {31'b0, bus.int_req}, 32'h1);
        checkOutput("lvl_rereq_id2", {27'b0, bus.int_id}, 32'd2);
        applyStimulus(1'b0, bitv(2), 1'b1, 1'b0, '0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        tick();
        checkOutput("lvl_drop", bus.pend_out, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        tick();
`endif

        // Randomized traffic: sparse lines, random handshake, rare resets.
        for (int n = 0; n < 1500; n++) begin
            irqR = $urandom & $urandom & $urandom;
            applyStimulus(($urandom_range(0, 99) == 0), irqR,
                          ($urandom_range(0, 7) != 0),
                          ($urandom_range(0, 15) == 0), $urandom | $urandom,
                          ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 2) == 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xintc.md
Name: xintc

Overview:
- Interrupt pending/arbitration stage for the xRV32I core, sitting directly upstream of the lowest-index priority encoder (xencdr).
- Captures 32 external interrupt lines into a pending register and applies a software-writable mask.
- Feeds the masked vector to an internal xencdr instance and presents one interrupt ID at a time to the core through a req/ack/done handshake.
- Index 0 has the highest priority.

Parameters:
- N_IRQ, 32, number of interrupt lines; fixed at 32 to match the 32-bit encoder input. Any other value is a configuration error.
- ID_W, 5, width of the interrupt ID; equals log2(N_IRQ).

Ports:
- clk  input  1  Single clock. All state updates on the rising edge.
- rst  input  1  Reset, synchronous, active-high.
- irq_in  input  32  Interrupt request lines, already synchronous to clk.
- gie  input  1  Global interrupt enable from the CSR unit.
- mask_we  input  1  Mask write strobe.
- mask_wdata  input  32  New mask value; 1 = enabled.
- mask_out  output  32  Current mask register.
- pend_out  output  32  Current pending register, unmasked.
- int_req  output  1  Interrupt request to the core.
- int_id  output  5  ID of the requested interrupt; valid while int_req=1.
- int_ack  input  1  Core accepts the interrupt (trap entry).
- int_done  input  1  Core finished the handler (mret).

Behaviour:
- Reset values (synchronous rst=1): pend=0, mask=0, irq_q=0, state=IDLE, int_req=0, int_id=0.
- A line already high when reset is released counts as a rising edge on the first cycle after reset.
- Edge capture:
  - irq_q <= irq_in every cycle.
  - rise = irq_in & ~irq_q.
  - pend[i] <= 1 when rise[i]=1.
- Pending clear: pend[i] <= 0 on the cycle int_ack=1 in state PEND with int_id==i.
  - If set and clear hit the same bit in the same cycle, set wins and the bit stays pending.
- Mask: mask <= mask_wdata when mask_we=1. The new mask takes effect on the next cycle.
- Encoder path: eff = pend & mask drives xencdr.val_in. The encoder output is combinational; any = |eff.
- State machine with three states:
  - IDLE: if gie=1 and any=1, latch int_id <= encoder output and go to PEND. Otherwise stay in IDLE.
  - PEND: int_req=1 and int_id is frozen. Mask writes, gie drops and new higher-priority edges do not retract or change the request. On int_ack=1, clear pend[int_id] and go to SERV.
  - SERV: int_req=0 and int_id holds its last value. On int_done=1, go to IDLE. No nesting.
- int_ack outside PEND and int_done outside SERV are ignored.
- int_req is registered, equal to (state==PEND).
- Latency: an edge sampled at clock edge k sets pend after edge k. int_req is high after edge k+1, so the minimum is 2 cycles from irq_in rising to int_req.
- After int_done, the next pending interrupt is requested 2 cycles later: IDLE for one cycle, then PEND.
- Asserting rst in any state returns the block to the reset values on the next edge; pending interrupts are lost.

Optional Feature:
- Macro: XINTC_LEVEL_EN.
- Defined (level-triggered):
  - pend <= irq_in every cycle; edge detection and the int_ack clear are removed.
  - The source must deassert its line inside the handler.
  - Arbitration and the state machine are unchanged.
- Undefined: edge-triggered behaviour as described under Behaviour.

Decomposition:
- defines.v holds:
  - `XINTC_N (32) and `XINTC_ID_W (5).
  - State encodings `XINTC_IDLE (2'd0), `XINTC_PEND (2'd1), `XINTC_SERV (2'd2).
- Sub-module: one instance of the existing xencdr for priority selection; no other sub-modules.

Test Plan:
- Reset check: rst=1 for 2 cycles with irq_in=32'h0000_0001 → after release, pend_out=0x1 one cycle later. int_req stays 0 because mask=0.
- Basic flow:
  - mask=0xFFFF_FFFF, gie=1, pulse irq_in[5] at edge k → int_req=1 and int_id=5 after edge k+1.
  - int_ack → pend_out[5]=0 and int_req=0.
  - int_done → back to IDLE.
- Priority and freeze:
  - Pend bits 9 and 3 together → int_id=3.
  - While in PEND, raise bit 1 → int_id stays 3.
  - After ack and done → int_id=1, then 9.
- Masking and gie:
  - mask=0x0000_0010 with pend bits 2 and 4 → int_id=4.
  - With gie=0 → int_req stays 0; pend_out=0x14 is retained.
- Set/clear collision: int_ack for id 7 on the same cycle irq_in[7] rises again → pend_out[7]=1 afterwards, and the state is SERV.
- XINTC_LEVEL_EN build: hold irq_in[2]=1 through ack and done → re-requested with int_id=2. Drop irq_in[2] → pend_out[2]=0 one cycle later.
